sr_fifo_q: RTL and testbench
============================

# sr_fifo_q

Synchronous first-word-fall-through FIFO that backs the CPU's push/pop instructions. The core writes the value of `rs1` on a push instruction and reads the head word on a pop instruction. The popped word is written to `rd` in the same cycle the pop is issued, so the head word is presented combinationally. The block is a single-clock-domain neighbour of the core: it consumes the core's `fifoPush`/`rd1` and feeds `fifoOut` back into the register-file write-data mux.

## Interface
- `DATA_WIDTH`, default 32: word width; must equal the core's `FIFO_DATA_WIDTH`.
- `DEPTH_LOG2`, default 3: log2 of the entry count (default 8 entries); legal range 1..8.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset; sampled on the rising edge of `clk`.
- `write_enable`  in  1: push request; one word per cycle.
- `write_data`  in  DATA_WIDTH: word to push.
- `read_enable`  in  1: pop request; the head word is consumed at the clock edge.
- `read_data`  out  DATA_WIDTH: head word, combinational (show-ahead).
- `full`  out  1: count == 2^DEPTH_LOG2.
- `empty`  out  1: count == 0.
- `count`  out  DEPTH_LOG2+1: number of stored words.
- `overflow`  out  1: sticky; a push was dropped.
- `underflow`  out  1: sticky; a pop was issued with no data available.

## Operation
- Storage: 2^DEPTH_LOG2 × DATA_WIDTH register array, write pointer `wp`, read pointer `rp` (DEPTH_LOG2 bits each) and `count` register.
- Pointers wrap modulo 2^DEPTH_LOG2 with natural binary overflow. No pointer compare is used for full/empty; both flags derive from `count`.
- Push is accepted when `write_enable` and (!full or `read_enable`):
  - `mem[wp]` <= `write_data`; `wp` <= `wp`+1.
- Pop is accepted when `read_enable` and !empty:
  - `rp` <= `rp`+1.
- Count update:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged when both are accepted or neither is.
- Full with push+pop: both are accepted. The popped word is the old head; the new word goes to the freed slot; count stays at max.
- Full with push only: the word is dropped, memory and pointers are unchanged, and `overflow` <= 1.
- Empty with pop (and no bypass, see Configuration): the pop is ignored, `read_data` = 0, and `underflow` <= 1.
- `read_data` = `mem[rp]` when !empty, else 0 (no X leaks into the register file).
- `overflow`/`underflow` remain set until `reset`; no other clear path exists.
- Memory contents are not reset. Only pointers, count and flags are reset.

## Timing
- Reset values: `wp`=0, `rp`=0, `count`=0, `empty`=1, `full`=0, `overflow`=0, `underflow`=0, `read_data`=0.
- `reset` has priority over any push or pop in the same cycle. The entire FIFO is flushed regardless of contents, including reset asserted mid-stream.
- Write-to-read latency is 1 cycle: a word pushed at edge N is visible on `read_data` after edge N (non-empty case).
- Pop latency is 0 cycles: `read_data` is valid in the cycle `read_enable` is asserted, and the next word appears after the edge.
- `full`, `empty` and `count` are registered-state derived and change only after a clock edge.
- `overflow`/`underflow` assert on the edge following the offending request.

## Configuration
- `SR_FIFO_BYPASS_EN` defined:
  - When empty and `write_enable`=1, `read_data` = `write_data` combinationally.
  - A simultaneous `read_enable` consumes that word: nothing is stored, pointers and count are unchanged, and no underflow is raised.
  - With `write_enable`=0, empty behaviour is as without the macro.
- `SR_FIFO_BYPASS_EN` undefined:
  - Empty push+pop stores the word (count becomes 1) and the pop is ignored with `underflow` <= 1.
  - `read_data` = 0 that cycle.

## Test plan
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles → `count`=3; `read_data`=0x11. Pop three times → 0x11, 0x22, 0x33 in order, then `empty`=1 and `read_data`=0.
- Push 8 words 0xA0..0xA7 (DEPTH_LOG2=3) → `full`=1. A 9th push of 0xFF → dropped, `overflow`=1, `count`=8. Drain → 0xA0..0xA7 with no 0xFF.
- Fill to full, then push 0xB0 with a simultaneous pop → pop returns 0xA0, `count` stays 8, and 0xB0 emerges last. Repeat 20 times across pointer wrap → ordering is preserved.
- Pop on empty with no push → `underflow`=1, `read_data`=0, `count`=0. Flag persists through later normal traffic until `reset`.
- Empty, push 0x5A with simultaneous pop:
  - With `SR_FIFO_BYPASS_EN` → `read_data`=0x5A that cycle and `count`=0 after.
  - Without it → `read_data`=0, `count`=1, `underflow`=1.
- With 5 words stored, assert `reset` together with push+pop → after the edge, `count`=0, `empty`=1, both flags 0, and the next push 0x77 reads back 0x77.

Source files
------------

// File: rtl/sr_fifo_q.sv
// sr_fifo_q: single-clock show-ahead FIFO that backs the core's push/pop instructions.
// Optional macro SR_FIFO_BYPASS_EN forwards write_data straight to read_data while empty.
module sr_fifo_q #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  write_enable,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  read_enable,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wp;
    logic [DEPTH_LOG2-1:0] rp;
    logic                  bypassHit;
    logic                  pushAccept;
    logic                  popAccept;
    logic                  underflowHit;

    assign full  = (count == FULL_COUNT);
    assign empty = (count == '0);

    // An empty FIFO never exposes stale memory: it shows zero, or the incoming word when bypassing.
`ifdef SR_FIFO_BYPASS_EN
    assign bypassHit = empty && write_enable && read_enable;
    assign read_data = empty ? (write_enable ? write_data : '0) : mem[rp];
`else
    assign bypassHit = 1'b0;
    assign read_data = empty ? '0 : mem[rp];
`endif

    assign pushAccept   = write_enable && (!full || read_enable) && !bypassHit;
    assign popAccept    = read_enable && !empty;
    assign underflowHit = read_enable && empty && !bypassHit;

    always_ff @(posedge clk) begin
        if (!reset && pushAccept) begin
            mem[wp] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp        <= '0;
            rp        <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (pushAccept) begin
                wp <= wp + 1'b1;
            end
            if (popAccept) begin
                rp <= rp + 1'b1;
            end
            case ({pushAccept, popAccept})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (write_enable && full && !read_enable) begin
                overflow <= 1'b1;
            end
            if (underflowHit) begin
                underflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sr_fifo_q.sv
// Scoreboard bench for sr_fifo_q: a queue-based reference model predicts popped words,
// and a negedge monitor compares them independently of the stimulus driver.
module tb_sr_fifo_q;

    localparam int DW    = 32;
    localparam int DL    = 3;
    localparam int DEPTH = 1 << DL;
`ifdef SR_FIFO_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          write_enable = 1'b0;
    logic [DW-1:0] write_data = '0;
    logic          read_enable = 1'b0;
    logic [DW-1:0] read_data;
    logic          full;
    logic          empty;
    logic [DL:0]   count;
    logic          overflow;
    logic          underflow;

    int compared   = 0;
    int mismatched = 0;

    logic [DW-1:0] modelQ[$];
    logic [DW-1:0] expQ[$];
    bit            modelOver  = 1'b0;
    bit            modelUnder = 1'b0;
    bit            checkEnable = 1'b0;

    always #5 clk = ~clk;

    sr_fifo_q #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk(clk),
        .reset(reset),
        .write_enable(write_enable),
        .write_data(write_data),
        .read_enable(read_enable),
        .read_data(read_data),
        .full(full),
        .empty(empty),
        .count(count),
        .overflow(overflow),
        .underflow(underflow)
    );

    task automatic compare(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    // State flags are compared against the model once the previous edge has settled.
    task automatic checkOutput();
        if (!checkEnable) return;
        compare("count", DW'(count), DW'(modelQ.size()));
        compare("empty", DW'(empty), DW'(modelQ.size() == 0));
        compare("full", DW'(full), DW'(modelQ.size() == DEPTH));
        compare("overflow", DW'(overflow), DW'(modelOver));
        compare("underflow", DW'(underflow), DW'(modelUnder));
    endtask

    task automatic applyStimulus(input bit rst, input bit we, input logic [DW-1:0] wd, input bit re);
        int sz;
        bit byp;
        bit pushOk;
        bit popOk;
        @(posedge clk);
        #1;
        checkOutput();
        reset        = rst;
        write_enable = we;
        write_data   = wd;
        read_enable  = re;
        sz  = modelQ.size();
        byp = BYP && (sz == 0) && we && re;
        if (re) begin
            expQ.push_back(sz > 0 ? modelQ[0] : (byp ? wd : '0));
        end
        if (rst) begin
            modelQ.delete();
            modelOver   = 1'b0;
            modelUnder  = 1'b0;
            checkEnable = 1'b1;
        end else if (!byp) begin
            pushOk = we && ((sz < DEPTH) || re);
            popOk  = re && (sz > 0);
            if (popOk) void'(modelQ.pop_front());
            if (pushOk) modelQ.push_back(wd);
            if (we && !pushOk) modelOver = 1'b1;
            if (re && sz == 0) modelUnder = 1'b1;
        end
    endtask

    // Monitor: every cycle that pops, the DUT's head word must match the next expected entry.
    initial begin
        logic [DW-1:0] exp;
        forever begin
            @(negedge clk);
            if (read_enable === 1'b1) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL scoreboard at %0t: pop seen, got 0x%0h, expected no pop", $time, read_data);
                end else begin
                    exp = expQ.pop_front();
                    compare("read_data", read_data, exp);
                end
            end
        end
    end

    initial begin
        int writePct;
        int readPct;
        applyStimulus(1, 0, '0, 0);
        applyStimulus(1, 0, '0, 0);

        applyStimulus(0, 1, 32'h11, 0);
        applyStimulus(0, 1, 32'h22, 0);
        applyStimulus(0, 1, 32'h33, 0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, 1);
        applyStimulus(0, 0, '0, 1);
        applyStimulus(0, 1, 32'h44, 0);
        applyStimulus(0, 0, '0, 1);

        applyStimulus(1, 0, '0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 32'hA0 + DW'(i), 0);
        applyStimulus(0, 1, 32'hFF, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, '0, 1);

        applyStimulus(1, 0, '0, 0);
        for (int i = 0; i < 8; i++) applyStimulus(0, 1, 32'hA0 + DW'(i), 0);
        for (int i = 0; i < 20; i++) applyStimulus(0, 1, 32'hB0 + DW'(i), 1);
        for (int i = 0; i < 8; i++) applyStimulus(0, 0, '0, 1);

        applyStimulus(1, 0, '0, 0);
        applyStimulus(0, 1, 32'h5A, 1);
        applyStimulus(0, 0, '0, 0);

        applyStimulus(1, 0, '0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 32'hC0 + DW'(i), 0);
        applyStimulus(1, 1, 32'hEE, 1);
        applyStimulus(0, 1, 32'h77, 0);
        applyStimulus(0, 0, '0, 1);

        // Random phases with shifting push/pop bias to visit full, empty and wrap.
        for (int phase = 0; phase < 15; phase++) begin
            writePct = $urandom_range(10, 90);
            readPct  = $urandom_range(10, 90);
            for (int c = 0; c < 200; c++) begin
                applyStimulus(($urandom_range(0, 99) == 0),
                              ($urandom_range(0, 99) < writePct),
                              DW'($urandom()),
                              ($urandom_range(0, 99) < readPct));
            end
        end

        applyStimulus(0, 0, '0, 0);
        applyStimulus(0, 0, '0, 0);
        @(negedge clk);
        #1;
        compare("scoreboard_leftover", DW'(expQ.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
